// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - register file access bus: write port shared with read port 3, plus two read-only ports
interface reg_file_if #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 4
);
    logic                 regWrite;
    logic [WIDTH-1:0]     DataIn;
    logic [ADDR_BITS-1:0] Read1;
    logic [ADDR_BITS-1:0] Read2;
    logic [ADDR_BITS-1:0] Read3;
    logic [WIDTH-1:0]     Data1;
    logic [WIDTH-1:0]     Data2;
    logic [WIDTH-1:0]     Data3;

    modport master (
        output regWrite, DataIn, Read1, Read2, Read3,
        input  Data1, Data2, Data3
    );

    modport slave (
        input  regWrite, DataIn, Read1, Read2, Read3,
        output Data1, Data2, Data3
    );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 16x16 register file, three async reads, one sync write at Read3
// Optional write-through forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module reg_file #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic           CLK,
    input  logic           RST,
    reg_file_if.slave      bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.regWrite) begin
            regs[bus.Read3] <= bus.DataIn;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd;

    // Forwarding is suppressed during reset, since the write it would anticipate never lands.
    always_comb begin
        fwd       = bus.regWrite && !RST;
        bus.Data1 = (fwd && (bus.Read1 == bus.Read3)) ? bus.DataIn : regs[bus.Read1];
        bus.Data2 = (fwd && (bus.Read2 == bus.Read3)) ? bus.DataIn : regs[bus.Read2];
        bus.Data3 = fwd ? bus.DataIn : regs[bus.Read3];
    end
`else
    always_comb begin
        bus.Data1 = regs[bus.Read1];
        bus.Data2 = regs[bus.Read2];
        bus.Data3 = regs[bus.Read3];
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file against an array reference model
module tb_reg_file;
    logic        clk;
    logic        rst;
    logic [15:0] model [16];
    int          total;
    int          bad;

    reg_file_if #(.WIDTH(16), .ADDR_BITS(4)) bus ();

    reg_file #(.WIDTH(16), .ADDR_BITS(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value a read port should show right now, given the stored model and the inputs being driven.
    function automatic logic [15:0] expect_read(input logic [3:0] addr);
`ifdef REGFILE_BYPASS_EN
        if (bus.regWrite && !rst && addr == bus.Read3) return bus.DataIn;
`endif
        return model[addr];
    endfunction

    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        end else if (bus.regWrite) begin
            model[bus.Read3] = bus.DataIn;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
        bus.regWrite = 1'b1;
        bus.Read3    = a;
        bus.DataIn   = d;
        tick();
        bus.regWrite = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.regWrite = 1'b0;
        bus.DataIn = 16'h0000;
        bus.Read1 = 4'd1; bus.Read2 = 4'd2; bus.Read3 = 4'd3;
        tick();
        rst = 1'b0;
        #1;
        total++; if (bus.Data1 !== 16'h0000) begin bad++; $display("FAIL reset_d1 got=%h want=0000", bus.Data1); end
        total++; if (bus.Data2 !== 16'h0000) begin bad++; $display("FAIL reset_d2 got=%h want=0000", bus.Data2); end
        total++; if (bus.Data3 !== 16'h0000) begin bad++; $display("FAIL reset_d3 got=%h want=0000", bus.Data3); end
    endtask

    task automatic test_write_readback();
        write_reg(4'd1, 16'h0F0F);
        write_reg(4'd2, 16'hF0F0);
        write_reg(4'd3, 16'hAAAA);
        bus.Read1 = 4'd1; bus.Read2 = 4'd2; bus.Read3 = 4'd3;
        #1;
        total++; if (bus.Data1 !== 16'h0F0F) begin bad++; $display("FAIL readback_d1 got=%h want=0f0f", bus.Data1); end
        total++; if (bus.Data2 !== 16'hF0F0) begin bad++; $display("FAIL readback_d2 got=%h want=f0f0", bus.Data2); end
        total++; if (bus.Data3 !== 16'hAAAA) begin bad++; $display("FAIL readback_d3 got=%h want=aaaa", bus.Data3); end
    endtask

    task automatic test_write_disable();
        bus.regWrite = 1'b0;
        bus.DataIn = 16'h1234;
        bus.Read3 = 4'd1;
        tick();
        total++; if (bus.Data3 !== 16'h0F0F) begin bad++; $display("FAIL write_disable got=%h want=0f0f", bus.Data3); end
    endtask

    task automatic test_aliased();
        bus.Read1 = 4'd2; bus.Read2 = 4'd2; bus.Read3 = 4'd2;
        #1;
        total++; if (bus.Data1 !== 16'hF0F0) begin bad++; $display("FAIL alias_d1 got=%h want=f0f0", bus.Data1); end
        total++; if (bus.Data2 !== 16'hF0F0) begin bad++; $display("FAIL alias_d2 got=%h want=f0f0", bus.Data2); end
        total++; if (bus.Data3 !== 16'hF0F0) begin bad++; $display("FAIL alias_d3 got=%h want=f0f0", bus.Data3); end
        write_reg(4'd15, 16'hFFFF);
        write_reg(4'd0, 16'h5555);
        bus.Read1 = 4'd15; bus.Read2 = 4'd0; bus.Read3 = 4'd0;
        #1;
        total++; if (bus.Data1 !== 16'hFFFF) begin bad++; $display("FAIL r15_read got=%h want=ffff", bus.Data1); end
        total++; if (bus.Data2 !== 16'h5555) begin bad++; $display("FAIL r0_read got=%h want=5555", bus.Data2); end
    endtask

    task automatic test_reset_priority();
        write_reg(4'd4, 16'h4444);
        rst = 1'b1;
        bus.regWrite = 1'b1;
        bus.DataIn = 16'hBEEF;
        bus.Read3 = 4'd4;
        tick();
        rst = 1'b0;
        bus.regWrite = 1'b0;
        bus.Read1 = 4'd1;
        #1;
        total++; if (bus.Data3 !== 16'h0000) begin bad++; $display("FAIL rst_prio_r4 got=%h want=0000", bus.Data3); end
        total++; if (bus.Data1 !== 16'h0000) begin bad++; $display("FAIL rst_prio_r1 got=%h want=0000", bus.Data1); end
    endtask

    task automatic test_bypass();
        logic [15:0] want;
        write_reg(4'd5, 16'h1111);
        bus.regWrite = 1'b1;
        bus.Read3 = 4'd5; bus.Read1 = 4'd5; bus.Read2 = 4'd6;
        bus.DataIn = 16'hC0DE;
        #1;
`ifdef REGFILE_BYPASS_EN
        want = 16'hC0DE;
`else
        want = 16'h1111;
`endif
        total++; if (bus.Data1 !== want) begin bad++; $display("FAIL bypass_pre got=%h want=%h", bus.Data1, want); end
        tick();
        bus.regWrite = 1'b0;
        #1;
        total++; if (bus.Data1 !== 16'hC0DE) begin bad++; $display("FAIL bypass_post got=%h want=c0de", bus.Data1); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            rst          = ($urandom_range(0, 39) == 0);
            bus.regWrite = $urandom_range(0, 1);
            bus.DataIn   = 16'($urandom);
            bus.Read1    = 4'($urandom);
            bus.Read2    = ($urandom_range(0, 3) == 0) ? bus.Read1 : 4'($urandom);
            bus.Read3    = 4'($urandom);
            #1;
            total++; if (bus.Data1 !== expect_read(bus.Read1)) begin bad++; $display("FAIL rand_d1 iter=%0d got=%h want=%h", n, bus.Data1, expect_read(bus.Read1)); end
            total++; if (bus.Data2 !== expect_read(bus.Read2)) begin bad++; $display("FAIL rand_d2 iter=%0d got=%h want=%h", n, bus.Data2, expect_read(bus.Read2)); end
            total++; if (bus.Data3 !== expect_read(bus.Read3)) begin bad++; $display("FAIL rand_d3 iter=%0d got=%h want=%h", n, bus.Data3, expect_read(bus.Read3)); end
            tick();
        end
        rst = 1'b0;
        bus.regWrite = 1'b0;
        for (int a = 0; a < 16; a++) begin
            bus.Read1 = 4'(a);
            #1;
            total++; if (bus.Data1 !== model[a]) begin bad++; $display("FAIL rand_final r%0d got=%h want=%h", a, bus.Data1, model[a]); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.regWrite = 1'b0;
        bus.DataIn = 16'h0000;
        bus.Read1 = 4'd0; bus.Read2 = 4'd0; bus.Read3 = 4'd0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        @(posedge clk);
        #1;
        test_reset();
        test_write_readback();
        test_write_disable();
        test_aliased();
        test_reset_priority();
        test_bypass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
